// File: rtl/debug_uart_tx_if.sv
// Bus bundle for debug_uart_tx: trigger, snapshot ports and the serial-side status outputs.
// The master drives trigger/ports; the slave (serializer) drives tx and status.
interface debug_uart_tx_if;
    logic       trigger;
    logic [7:0] debug_port1;
    logic [7:0] debug_port2;
    logic [7:0] debug_port3;
    logic [7:0] debug_port4;
    logic [7:0] debug_port5;
    logic [7:0] debug_port6;
    logic [7:0] debug_port7;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic       overrun;
    logic [7:0] seq;

    modport master (
        output trigger, debug_port1, debug_port2, debug_port3, debug_port4,
               debug_port5, debug_port6, debug_port7,
        input  tx, busy, frame_done, overrun, seq
    );

    modport slave (
        input  trigger, debug_port1, debug_port2, debug_port3, debug_port4,
               debug_port5, debug_port6, debug_port7,
        output tx, busy, frame_done, overrun, seq
    );
endinterface

// File: rtl/debug_uart_tx.sv
// Debug-port frame serializer: snapshots seven 8-bit ports on trigger and sends
// SYNC, seq, p1..p7, chk as contiguous 8N1 bytes on tx.
module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic           clk,
    input  logic           nreset,
    debug_uart_tx_if.slave bus
);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [3:0]    byte_idx;
    logic [7:0]    shift;
    logic [7:0]    sh_seq;
    logic [7:0]    sh_p [7];
    logic [7:0]    chk;
    logic [7:0]    next_byte;
    logic          bit_end;

    assign bit_end = (baud == BAUD_LAST);

    always_comb begin
        chk = sh_seq;
        for (int unsigned i = 0; i < 7; i++) chk = chk ^ sh_p[i];
    end

    // Byte that follows the one currently in flight.
    always_comb begin
        next_byte = SYNC_BYTE;
        case (byte_idx)
            4'd0:    next_byte = sh_seq;
            4'd1:    next_byte = sh_p[0];
            4'd2:    next_byte = sh_p[1];
            4'd3:    next_byte = sh_p[2];
            4'd4:    next_byte = sh_p[3];
            4'd5:    next_byte = sh_p[4];
            4'd6:    next_byte = sh_p[5];
            4'd7:    next_byte = sh_p[6];
            4'd8:    next_byte = chk;
            default: next_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            state          <= IDLE;
            baud           <= '0;
            bit_idx        <= '0;
            byte_idx       <= '0;
            shift          <= '0;
            sh_seq         <= '0;
            for (int unsigned i = 0; i < 7; i++) sh_p[i] <= '0;
            bus.tx         <= 1'b1;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.seq        <= '0;
        end else begin
            bus.frame_done <= 1'b0;
            if (bus.trigger && state != IDLE) bus.overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.trigger) begin
                        sh_seq   <= bus.seq;
                        sh_p[0]  <= bus.debug_port1;
                        sh_p[1]  <= bus.debug_port2;
                        sh_p[2]  <= bus.debug_port3;
                        sh_p[3]  <= bus.debug_port4;
                        sh_p[4]  <= bus.debug_port5;
                        sh_p[5]  <= bus.debug_port6;
                        sh_p[6]  <= bus.debug_port7;
                        bus.seq  <= bus.seq + 8'd1;
                        shift    <= SYNC_BYTE;
                        byte_idx <= '0;
                        baud     <= '0;
                        bus.tx   <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        bus.tx  <= shift[0];
                        shift   <= shift >> 1;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            bus.tx <= 1'b1;
                            state  <= STOP;
                        end else begin
                            bus.tx  <= shift[0];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (byte_idx < 4'd9) begin
                            byte_idx <= byte_idx + 4'd1;
                            shift    <= next_byte;
                            bus.tx   <= 1'b0;
                            state    <= START;
                        end else begin
                            byte_idx       <= '0;
                            bus.busy       <= 1'b0;
                            bus.frame_done <= 1'b1;
                            state          <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_uart_tx.sv
// Scoreboard bench for debug_uart_tx: stimulus pushes expected frame bytes, per-DUT
// monitors decode tx and compare. A second fast-baud instance covers seq wrap.
module tb_debug_uart_tx;
    localparam int C1 = 4;
    localparam int C2 = 2;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    debug_uart_tx_if b1();
    debug_uart_tx_if b2();

    debug_uart_tx #(.CLKS_PER_BIT(C1), .SYNC_BYTE(8'hA5)) dut1 (.clk(clk), .nreset(nreset), .bus(b1));
    debug_uart_tx #(.CLKS_PER_BIT(C2), .SYNC_BYTE(8'hA5)) dut2 (.clk(clk), .nreset(nreset), .bus(b2));

    int total = 0;
    int bad   = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    bit abort1 = 1'b0;
    bit abort2 = 1'b0;
    logic [7:0]  exp_seq [2];
    logic [55:0] pv [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic txv(input int w);
        return (w == 0) ? b1.tx : b2.tx;
    endfunction

    function automatic bit take_abort(input int w);
        bit a;
        if (w == 0) begin a = abort1; abort1 = 1'b0; end
        else        begin a = abort2; abort2 = 1'b0; end
        return a;
    endfunction

    task automatic set_ports(input int w, input logic [55:0] v);
        if (w == 0) begin
            {b1.debug_port7, b1.debug_port6, b1.debug_port5, b1.debug_port4,
             b1.debug_port3, b1.debug_port2, b1.debug_port1} = v;
        end else begin
            {b2.debug_port7, b2.debug_port6, b2.debug_port5, b2.debug_port4,
             b2.debug_port3, b2.debug_port2, b2.debug_port1} = v;
        end
    endtask

    task automatic set_trig(input int w, input logic t);
        if (w == 0) b1.trigger = t; else b2.trigger = t;
    endtask

    // Decodes one 8N1 byte per iteration, sampling every clock at negedge.
    task automatic monitor(input int w);
        int c;
        logic [7:0] data;
        logic s;
        bit ok, ab;
        c = (w == 0) ? C1 : C2;
        forever begin
            @(negedge clk);
            if (take_abort(w)) continue;
            if (txv(w) !== 1'b0) continue;
            ok = 1'b1; ab = 1'b0; data = '0;
            for (int k = 1; k < c; k++) begin
                @(negedge clk);
                if (take_abort(w)) ab = 1'b1;
                if (txv(w) !== 1'b0) ok = 1'b0;
            end
            for (int b = 0; b < 8; b++) begin
                for (int k = 0; k < c; k++) begin
                    @(negedge clk);
                    if (take_abort(w)) ab = 1'b1;
                    s = txv(w);
                    if (k == 0) data[b] = s;
                    else if (s !== data[b]) ok = 1'b0;
                end
            end
            for (int k = 0; k < c; k++) begin
                @(negedge clk);
                if (take_abort(w)) ab = 1'b1;
                if (txv(w) !== 1'b1) ok = 1'b0;
            end
            if (ab) continue;
            check($sformatf("framing%0d", w), {31'd0, ok}, 32'd1);
            if (w == 0 && q1.size() == 0 || w == 1 && q2.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_byte%0d: got %0h expected none", w, data);
            end else if (w == 0) begin
                check("byte0", {24'd0, data}, {24'd0, q1.pop_front()});
            end else begin
                check("byte1", {24'd0, data}, {24'd0, q2.pop_front()});
            end
        end
    endtask

    task automatic push_frame(input int w, input logic [7:0] s, input logic [55:0] v);
        logic [7:0] f [10];
        logic [7:0] chk;
        f[0] = 8'hA5;
        f[1] = s;
        chk  = s;
        for (int i = 0; i < 7; i++) begin
            f[2+i] = v[8*i +: 8];
            chk    = chk ^ v[8*i +: 8];
        end
        f[9] = chk;
        for (int i = 0; i < 10; i++) begin
            if (w == 0) q1.push_back(f[i]); else q2.push_back(f[i]);
        end
    endtask

    // Trigger sampled at the posedge between the two negedges; returns after edge E.
    task automatic fire(input int w);
        push_frame(w, exp_seq[w], pv[w]);
        set_trig(w, 1'b1);
        @(negedge clk);
        set_trig(w, 1'b0);
        exp_seq[w] = exp_seq[w] + 8'd1;
        check("busy_after_trig", {31'd0, (w == 0) ? b1.busy : b2.busy}, 32'd1);
        check("start_bit", {31'd0, txv(w)}, 32'd0);
        check("seq_after_trig", {24'd0, (w == 0) ? b1.seq : b2.seq}, {24'd0, exp_seq[w]});
    endtask

    // Waits for frame_done (expected fr cycles after E); optional trigger sampled at E+poke.
    task automatic run_frame(input int w, input int fr, input int poke);
        int got;
        got = -1;
        for (int n = 1; n <= fr + 20; n++) begin
            @(negedge clk);
            if (n == poke) begin
                set_trig(w, 1'b0);
                check("overrun_set", {31'd0, (w == 0) ? b1.overrun : b2.overrun}, 32'd1);
                check("seq_unchanged", {24'd0, (w == 0) ? b1.seq : b2.seq}, {24'd0, exp_seq[w]});
            end
            if (((w == 0) ? b1.frame_done : b2.frame_done) === 1'b1) begin
                got = n;
                break;
            end
            if (n == poke - 1) begin
                check("overrun_before", {31'd0, (w == 0) ? b1.overrun : b2.overrun}, 32'd0);
                set_trig(w, 1'b1);
            end
        end
        set_trig(w, 1'b0);
        check("frame_done_latency", got, fr);
        check("busy_at_done", {31'd0, (w == 0) ? b1.busy : b2.busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        fork
            monitor(0);
            monitor(1);
        join_none

        nreset = 1'b1;
        exp_seq[0] = '0; exp_seq[1] = '0;
        pv[0] = 56'h77_66_55_44_33_22_11;
        pv[1] = 56'h07_06_05_04_03_02_01;
        b1.trigger = 1'b0; b2.trigger = 1'b0;
        set_ports(0, pv[0]);
        set_ports(1, pv[1]);
        repeat (3) @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);

        check("rst_tx", {31'd0, b1.tx}, 32'd1);
        check("rst_busy", {31'd0, b1.busy}, 32'd0);
        check("rst_frame_done", {31'd0, b1.frame_done}, 32'd0);
        check("rst_overrun", {31'd0, b1.overrun}, 32'd0);
        check("rst_seq", {24'd0, b1.seq}, 32'd0);

        // Frame A then frame B at minimum spacing.
        fire(0);
        run_frame(0, 100 * C1, 0);
        check("seq_after_A", {24'd0, b1.seq}, 32'd1);
        fire(0);
        run_frame(0, 100 * C1, 0);
        check("seq_after_B", {24'd0, b1.seq}, 32'd2);

        // Snapshot isolation, plus a trigger coincident with the last stop-bit edge.
        fire(0);
        set_ports(0, {56{1'b1}});
        run_frame(0, 100 * C1, 100 * C1);
        check("frame_done_pulse", {31'd0, b1.frame_done}, 32'd1);
        set_ports(0, pv[0]);
        repeat (20) @(negedge clk);
        check("no_frame_after_overrun", {31'd0, b1.busy}, 32'd0);
        check("seq_after_C", {24'd0, b1.seq}, 32'd3);

        // Reset mid-frame.
        fire(0);
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            if (n == 149) begin
                nreset = 1'b1;
                abort1 = 1'b1;
                abort2 = 1'b1;
            end
        end
        nreset = 1'b0;
        q1.delete();
        exp_seq[0] = '0;
        check("midrst_tx", {31'd0, b1.tx}, 32'd1);
        check("midrst_busy", {31'd0, b1.busy}, 32'd0);
        check("midrst_seq", {24'd0, b1.seq}, 32'd0);
        check("midrst_overrun", {31'd0, b1.overrun}, 32'd0);
        pulses = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (b1.frame_done === 1'b1) pulses++;
        end
        check("no_done_after_rst", pulses, 0);

        // Full frame with seq 00, second trigger 50 cycles in is dropped.
        fire(0);
        run_frame(0, 100 * C1, 50);
        check("overrun_sticky", {31'd0, b1.overrun}, 32'd1);
        check("seq_after_overrun", {24'd0, b1.seq}, 32'd1);
        repeat (20) @(negedge clk);
        check("idle_after_overrun", {31'd0, b1.busy}, 32'd0);

        // 256 back-to-back frames at minimum spacing on the fast instance.
        for (int i = 0; i < 256; i++) begin
            fire(1);
            run_frame(1, 100 * C2, 0);
        end
        check("wrap_seq", {24'd0, b2.seq}, 32'd0);
        check("wrap_overrun", {31'd0, b2.overrun}, 32'd0);

        repeat (50) @(negedge clk);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_uart_tx.md
# debug_uart_tx

Serializer for the CPU's debug-port bus: on a trigger it snapshots the seven 8-bit debug ports and sends them to the host debugger as a framed 8N1 UART byte stream. It sits between the CPU top level and the board's serial TX pin. The `trigger` input is driven from the CPU's writeback state, so the host receives one frame per retired instruction while the link keeps up.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per UART bit. Must be at least 2.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.

- `clk`  in  1  system clock
- `nreset`  in  1  reset: synchronous, active-high; clock clk
- `trigger`  in  1  single-cycle request to send a frame
- `debug_port1`..`debug_port7`  in  8 each  values to snapshot
- `tx`  out  1  UART line, idle high
- `busy`  out  1  high while a frame is in flight
- `frame_done`  out  1  one-cycle pulse after the last stop bit
- `overrun`  out  1  sticky; set when a trigger arrives while busy
- `seq`  out  8  sequence number of the next frame to be sent

## Operation
- Frame is 10 bytes, sent in this order: SYNC_BYTE, seq, p1, p2, p3, p4, p5, p6, p7, chk.
  - chk = seq ^ p1 ^ … ^ p7. SYNC_BYTE is not included in chk.
- Each byte is 8N1: one start bit (0), eight data bits LSB first, one stop bit (1).
- Bytes within a frame are contiguous: the next start bit immediately follows the previous stop bit.
- State machine: IDLE → START → DATA → STOP.
  - From STOP: go to START if byte index < 9, otherwise go to IDLE.
- Counters:
  - baud counter, 0..CLKS_PER_BIT-1
  - bit index, 0..7
  - byte index, 0..9
- Trigger acceptance: a trigger is accepted only when busy=0.
  - On acceptance, p1..p7 and the current seq are latched into shadow registers. chk is computed from the shadow registers.
  - Port changes during a frame have no effect on that frame.
- seq increments (mod 256) on every accepted trigger. The first frame after reset carries seq=0. After 255 the next value is 0.
- Trigger while busy=1 (including the frame_done cycle): the trigger is ignored, overrun is set to 1, and seq is unchanged.
- overrun clears only on reset.
- Reset values: tx=1, busy=0, frame_done=0, overrun=0, seq=0, state IDLE, all counters 0.
- Reset asserted mid-frame: on the next edge all outputs take their reset values. No frame_done is issued and the partial frame is abandoned.
- Reset and trigger in the same cycle: reset wins and the trigger is dropped.

## Timing
- Trigger sampled at edge E with busy=0:
  - busy=1 and tx=0 (start bit) from E onward.
  - seq output shows the incremented value from E onward.
- Bit durations:
  - every bit holds for exactly CLKS_PER_BIT cycles
  - byte = 10·CLKS_PER_BIT cycles
  - frame = 100·CLKS_PER_BIT cycles
- At edge E + 100·CLKS_PER_BIT: busy→0 and frame_done=1 for one cycle. tx is already 1 (stop bit) and stays 1.
- A new trigger can be accepted in the cycle after frame_done. Minimum trigger-to-trigger spacing without overrun is 100·CLKS_PER_BIT + 1 cycles.
- All outputs are registered; there are no combinational paths from inputs to tx.

## Test plan
- **Single frame** (CLKS_PER_BIT=4, ports = 11,22,33,44,55,66,77 hex, one trigger after reset):
  - tx decodes to A5,00,11,22,33,44,55,66,77,00
  - frame_done at trigger+400 cycles
  - seq reads 1 afterwards
- **Second frame**, same ports, triggered after frame_done: bytes A5,01,11,22,33,44,55,66,77,01.
- **Snapshot isolation**: change every port to FF one cycle after the trigger. The frame still carries the original values and chk is unchanged.
- **Overrun**: trigger at cycle 0 and again at cycle 50.
  - Only one frame is sent; the second trigger is dropped.
  - overrun=1 from cycle 51 and stays 1 after the frame.
  - seq=1.
  - A trigger coincident with frame_done also sets overrun.
- **Reset mid-frame**: assert nreset for 1 cycle at trigger+150.
  - Next cycle: tx=1, busy=0, seq=0, overrun=0.
  - No frame_done pulse.
  - A following trigger sends a full frame with seq=00.
- **Wrap and bit timing**: issue 256 non-overlapping triggers.
  - The 256th frame carries seq=FF, and the seq output reads 00 afterwards.
  - Every tx bit measures exactly CLKS_PER_BIT cycles, with stop bits = 1 and start bits = 0.
